// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_pkg
// Description : Shared image-pipeline defaults and kernel sum width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;
    localparam int c_PIX_W_DEFAULT  = 16;
    localparam int c_LINE_W_DEFAULT = 1024;
    localparam int c_SUM_EXTRA      = 4;
    localparam int c_SUM_W_DEFAULT  = c_PIX_W_DEFAULT + c_SUM_EXTRA;

    // The 1-2-1 x 1-2-1 kernel has total weight 16, so four guard bits suffice.
    function automatic int sum_width(input int pix_w);
        return pix_w + c_SUM_EXTRA;
    endfunction
endpackage
`default_nettype wire

// File: rtl/gauss_row_sum.sv
`default_nettype none
// ============================================================================
// Module      : gauss_row_sum
// Description : Weighted 1-2-1 sum of one window row, shift-based.
// Revision    : 1.0 - initial release
// ============================================================================
module gauss_row_sum #(
    parameter int PIX_W = 16
) (
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] c,
    output logic [PIX_W+1:0] sum
);
    assign sum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
endmodule
`default_nettype wire

// File: rtl/gauss3x3_filter.sv
`default_nettype none
// ============================================================================
// Module      : gauss3x3_filter
// Description : 3x3 Gaussian (1-2-1) filter, two-stage pipeline, no padding.
// Revision    : 1.0 - initial release
// ============================================================================
module gauss3x3_filter
    import img_pkg::*;
#(
    parameter int LINE_W = c_LINE_W_DEFAULT,
    parameter int PIX_W  = c_PIX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             en,
    input  logic [PIX_W-1:0] row0,
    input  logic [PIX_W-1:0] row1,
    input  logic [PIX_W-1:0] row2,
    output logic [PIX_W-1:0] dout,
    output logic             dout_valid,
    output logic             dout_eol
);
    localparam int c_COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int c_RS_W  = PIX_W + 2;
    localparam int c_SUM_W = sum_width(PIX_W);
    localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(LINE_W - 1);
    localparam logic [c_COL_W-1:0] c_COL_FIRST = c_COL_W'(2);

    logic [PIX_W-1:0]   r_win [3][3];   // [tap][column], column 2 is newest
    logic [PIX_W-1:0]   w_pix [3];
    logic [c_COL_W-1:0] r_col;
    logic [1:0]         r_row;
    logic [c_COL_W-1:0] w_acc_col;
    logic [1:0]         w_acc_row;
    logic               w_complete;
    logic               w_last;
    logic               r_win_valid;
    logic               r_win_eol;
    logic [c_RS_W-1:0]  w_rs    [3];
    logic [c_RS_W-1:0]  r_s1_rs [3];
    logic               r_s1_valid;
    logic               r_s1_eol;
    logic [c_SUM_W-1:0] w_total;
    logic [PIX_W-1:0]   r_dout;
    logic               r_dout_valid;
    logic               r_dout_eol;

    assign w_pix[0] = row0;
    assign w_pix[1] = row1;
    assign w_pix[2] = row2;

    // Position of the pixel being accepted this cycle; sof overrides the count.
    assign w_acc_col  = sof ? '0 : r_col;
    assign w_acc_row  = sof ? 2'd0 : r_row;
    assign w_last     = (w_acc_col == c_COL_LAST);
    assign w_complete = en && (w_acc_col >= c_COL_FIRST) && (w_acc_row == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (en) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
                r_win[i][2] <= w_pix[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= 2'd0;
        end else if (en) begin
            if (w_last) begin
                r_col <= '0;
                r_row <= (w_acc_row == 2'd2) ? 2'd2 : w_acc_row + 2'd1;
            end else begin
                r_col <= w_acc_col + c_COL_W'(1);
                r_row <= w_acc_row;
            end
        end
    end

    generate
        for (genvar g = 0; g < 3; g++) begin : g_row
            gauss_row_sum #(.PIX_W(PIX_W)) u_row_sum (
                .a   (r_win[g][0]),
                .b   (r_win[g][1]),
                .c   (r_win[g][2]),
                .sum (w_rs[g])
            );
        end
    endgenerate

    assign w_total = c_SUM_W'(r_s1_rs[0])
                   + (c_SUM_W'(r_s1_rs[1]) << 1)
                   + c_SUM_W'(r_s1_rs[2]);

    // Flags ride alongside the data; stages never stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_valid  <= 1'b0;
            r_win_eol    <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_eol     <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_eol   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_s1_rs[i] <= '0;
            end
        end else begin
            r_win_valid  <= w_complete;
            r_win_eol    <= w_complete && w_last;
            r_s1_valid   <= r_win_valid;
            r_s1_eol     <= r_win_eol;
            for (int i = 0; i < 3; i++) begin
                r_s1_rs[i] <= w_rs[i];
            end
            r_dout       <= w_total[c_SUM_W-1:4];
            r_dout_valid <= r_s1_valid;
            r_dout_eol   <= r_s1_eol;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_eol   = r_dout_eol;
endmodule
`default_nettype wire

// File: tb/tb_gauss3x3_filter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gauss3x3_filter
// Description : Directed self-checking bench for gauss3x3_filter (LINE_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gauss3x3_filter;
    localparam int LINE_W = 8;
    localparam int PIX_W  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             sof;
    logic             en;
    logic [PIX_W-1:0] row0;
    logic [PIX_W-1:0] row1;
    logic [PIX_W-1:0] row2;
    logic [PIX_W-1:0] dout;
    logic             dout_valid;
    logic             dout_eol;

    int n_vec = 0;
    int n_err = 0;
    int valid_cnt = 0;

    // Expected outputs queued two edges ahead of their appearance.
    logic             q0_v, q1_v, q0_e, q1_e;
    logic [PIX_W-1:0] q0_d, q1_d;

    gauss3x3_filter #(.LINE_W(LINE_W), .PIX_W(PIX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .en         (en),
        .row0       (row0),
        .row1       (row1),
        .row2       (row2),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_eol   (dout_eol)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_pipe();
        q0_v = 1'b0; q1_v = 1'b0; q0_e = 1'b0; q1_e = 1'b0;
        q0_d = '0;   q1_d = '0;
    endtask

    task automatic step(input string tag, input logic s, input logic e,
                        input logic [PIX_W-1:0] p0, input logic [PIX_W-1:0] p1,
                        input logic [PIX_W-1:0] p2, input logic xv, input logic xe,
                        input logic [PIX_W-1:0] xd);
        logic             ov, oe;
        logic [PIX_W-1:0] od;
        sof = s; en = e; row0 = p0; row1 = p1; row2 = p2;
        @(posedge clk);
        #1;
        ov = q1_v; oe = q1_e; od = q1_d;
        q1_v = q0_v; q1_e = q0_e; q1_d = q0_d;
        q0_v = xv;   q0_e = xv && xe; q0_d = xd;
        if (dout_valid === 1'b1) valid_cnt++;
        n_vec++;
        assert (dout_valid === ov) else begin
            n_err++;
            $error("FAIL %s valid: got %b want %b", tag, dout_valid, ov);
        end
        n_vec++;
        assert (dout_eol === oe) else begin
            n_err++;
            $error("FAIL %s eol: got %b want %b", tag, dout_eol, oe);
        end
        if (ov) begin
            n_vec++;
            assert (dout === od) else begin
                n_err++;
                $error("FAIL %s dout: got %0d want %0d", tag, dout, od);
            end
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    // One full line of a constant image; gen says whether this line is row 2.
    task automatic line(input string tag, input logic first, input logic gen,
                        input logic [PIX_W-1:0] v, input logic gap);
        for (int c = 0; c < LINE_W; c++) begin
            step(tag, first && (c == 0), 1'b1, v, v, v, gen && (c >= 2), c == LINE_W - 1, v);
            if (gap) idle(tag, 1);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_vec++;
        assert (got == want) else begin
            n_err++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    initial begin
        clear_pipe();
        rst = 1'b1; sof = 1'b0; en = 1'b0; row0 = '0; row1 = '0; row2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_int("reset_dout",  int'(dout), 0);
        check_int("reset_valid", int'(dout_valid), 0);
        check_int("reset_eol",   int'(dout_eol), 0);
        rst = 1'b0;

        // Constant 100 frame, continuous enable
        valid_cnt = 0;
        line("c100", 1'b1, 1'b0, 16'd100, 1'b0);
        line("c100", 1'b0, 1'b0, 16'd100, 1'b0);
        line("c100", 1'b0, 1'b1, 16'd100, 1'b0);
        line("c100", 1'b0, 1'b1, 16'd100, 1'b0);
        idle("c100", 2);
        check_int("c100_count", valid_cnt, 12);

        // Full-scale pixels must not overflow
        line("cmax", 1'b1, 1'b0, 16'hFFFF, 1'b0);
        line("cmax", 1'b0, 1'b0, 16'hFFFF, 1'b0);
        line("cmax", 1'b0, 1'b1, 16'hFFFF, 1'b0);
        idle("cmax", 2);

        // Impulse of 1600: middle tap then outer tap, swept across the window
        line("imp", 1'b1, 1'b0, 16'd0, 1'b0);
        line("imp", 1'b0, 1'b0, 16'd0, 1'b0);
        for (int c = 0; c < LINE_W; c++) begin
            step("imp_mid", 1'b0, 1'b1, 16'd0, (c == 4) ? 16'd1600 : 16'd0, 16'd0,
                 c >= 2, c == LINE_W - 1,
                 (c == 5) ? 16'd400 : ((c == 4 || c == 6) ? 16'd200 : 16'd0));
        end
        for (int c = 0; c < LINE_W; c++) begin
            step("imp_top", 1'b0, 1'b1, (c == 4) ? 16'd1600 : 16'd0, 16'd0, 16'd0,
                 c >= 2, c == LINE_W - 1,
                 (c == 5) ? 16'd200 : ((c == 4 || c == 6) ? 16'd100 : 16'd0));
        end
        idle("imp", 2);

        // Enable toggling 1,0,1,0
        valid_cnt = 0;
        line("entog", 1'b1, 1'b0, 16'd100, 1'b1);
        line("entog", 1'b0, 1'b0, 16'd100, 1'b1);
        line("entog", 1'b0, 1'b1, 16'd100, 1'b1);
        idle("entog", 2);
        check_int("entog_count", valid_cnt, 6);

        // sof mid-line at col 5: in-flight results drain, new frame warms up
        line("sofm", 1'b1, 1'b0, 16'd100, 1'b0);
        line("sofm", 1'b0, 1'b0, 16'd100, 1'b0);
        for (int c = 0; c < 5; c++)
            step("sofm_old", 1'b0, 1'b1, 16'd100, 16'd100, 16'd100, c >= 2, 1'b0, 16'd100);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < LINE_W; c++) begin
                step("sofm_new", (r == 0) && (c == 0), 1'b1, 16'd50, 16'd50, 16'd50,
                     (r == 2) && (c >= 2), c == LINE_W - 1, 16'd50);
            end
        end
        idle("sofm", 2);

        // Reset pulse mid-line with results in flight
        line("rstm", 1'b1, 1'b0, 16'd100, 1'b0);
        line("rstm", 1'b0, 1'b0, 16'd100, 1'b0);
        for (int c = 0; c < 4; c++)
            step("rstm_pre", 1'b0, 1'b1, 16'd100, 16'd100, 16'd100, c >= 2, 1'b0, 16'd100);
        rst = 1'b1;
        #1;
        check_int("rstm_dout",  int'(dout), 0);
        check_int("rstm_valid", int'(dout_valid), 0);
        check_int("rstm_eol",   int'(dout_eol), 0);
        clear_pipe();
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_cnt = 0;
        line("rstm_post", 1'b0, 1'b0, 16'd100, 1'b0);
        line("rstm_post", 1'b0, 1'b0, 16'd100, 1'b0);
        check_int("rstm_warmup_count", valid_cnt, 0);
        line("rstm_post", 1'b0, 1'b1, 16'd100, 1'b0);
        idle("rstm_post", 2);
        check_int("rstm_count", valid_cnt, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/gauss3x3_filter.md
GAUSS3X3_FILTER -- requirements
Module: gauss3x3_filter

Interface
REQ-001 Parameter LINE_W, default 1024, pixels per image line (minimum 3).
REQ-002 Parameter PIX_W, default 16, pixel width in bits.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sof  input  1  start-of-frame, sampled only when en=1, marks the first pixel of a frame.
REQ-006 en  input  1  input pixel valid; one column accepted per clk edge with en=1.
REQ-007 row0  input  PIX_W  current-line pixel.
REQ-008 row1  input  PIX_W  same column, one line earlier (line-buffer tap).
REQ-009 row2  input  PIX_W  same column, two lines earlier (line-buffer tap).
REQ-010 dout  output  PIX_W  filtered pixel.
REQ-011 dout_valid  output  1  dout holds a valid result for exactly this cycle.
REQ-012 dout_eol  output  1  asserted with dout_valid on the last valid output of a line.

Function
REQ-013 Window: 3x3 register array; on en=1 columns shift left and {row2,row1,row0} load into the rightmost column; when en=0 the window is held.
REQ-014 Column counter col: 0..LINE_W-1; increments on en=1; wraps from LINE_W-1 to 0.
REQ-015 Row counter row: increments when col wraps; saturates at 2.
REQ-016 On en=1 with sof=1: that pixel is taken as col=0, row=0, overriding the current count.
REQ-017 A window is complete when the accepting pixel has col>=2 and row==2; edge pixels produce no output (no border padding).
REQ-018 Kernel: sum = p00+2p01+p02+2p10+4p11+2p12+p20+2p21+p22, computed unsigned at PIX_W+4 bits with no overflow.
REQ-019 dout = sum >> 4, truncated to PIX_W bits, with no rounding.
REQ-020 Pipeline stage 1 registers the three weighted row sums at PIX_W+2 bits each; stage 2 registers the total and the shift.
REQ-021 Latency: a window completed at edge N gives dout/dout_valid at edge N+2, fixed and independent of en.
REQ-022 Pipeline stages advance every clk with no backpressure; the valid and eol flags travel with the data.
REQ-023 dout_eol is asserted for the window whose accepting pixel has col==LINE_W-1.
REQ-024 Each line with row==2 yields exactly LINE_W-2 valid outputs.
REQ-025 sof mid-line: in-flight pipeline results still emerge; the new frame produces no output until its own row==2, col>=2.

Reset
REQ-026 While rst is high: col=0, row=0, window=0, pipeline registers=0, dout=0, dout_valid=0, dout_eol=0.
REQ-027 Reset mid-operation discards all in-flight results; no dout_valid occurs until a full 3-row warm-up after release.

Structure
REQ-028 A shared package img_pkg holds PIX_W, LINE_W defaults and the sum width constant (PIX_W+4).
REQ-029 One sub-module, gauss_row_sum, computes a+2b+c for one window row and is instantiated three times.
REQ-030 Weighting uses shifts only; no multipliers.

Verification
REQ-031 Constant frame, all pixels 100, LINE_W=8, en=1 continuously -> from row 2 on, every dout=100, 6 valids per line, dout_eol on every 6th.
REQ-032 All pixels 0xFFFF -> dout=0xFFFF with no overflow (sum=1048560).
REQ-033 Single pixel 1600 at centre, zeros elsewhere -> the window containing it at centre gives dout=400, at edge 200, at corner 100.
REQ-034 en toggling 1,0,1,0 with constant 100 -> output count and values match the continuous run, and each result appears 2 cycles after its accepting edge.
REQ-035 sof asserted at col=5 mid-line -> counters restart, in-flight 2 results still appear, then no valid until the new frame's row 2, col 2.
REQ-036 rst pulsed for 1 cycle mid-line -> outputs go to 0 immediately; the first valid appears only after 2 full lines plus 3 pixels.
